vga_out_stage: RTL and testbench



---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_out_stage.sv | 125 ++++++++++++
 tb/tb_vga_out_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared widths, 640x480 timing constants and the colour replication helper
// used by the VGA output stage.
package vga_pkg;

    localparam int RGB3_W    = 3;
    localparam int RED_W     = 5;
    localparam int GREEN_W   = 6;
    localparam int BLUE_W    = 5;
    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    // Replicates one source bit across the low 'width' bits (width <= 8).
    function automatic logic [7:0] expand_bits(input logic b, input int width);
        return b ? (8'hFF >> (8 - width)) : 8'h00;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register shift line with asynchronous active-low reset and a
// configurable reset value loaded into every stage.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// VGA pin output stage: aligned sync/colour pipeline, blanking, 5/6/5 expansion,
// frame counter and heartbeat. Optional test bars under macro VGA_TESTBAR_EN.
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int LATENCY          = 2,
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int HSYNC_ACTIVE_LOW = 1,
    parameter int FRAME_DIV        = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 display_on,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic [RGB3_W-1:0]    rgb_in,
    input  logic                 pattern_sel,
    output logic                 hsync,
    output logic                 vsync,
    output logic [RED_W-1:0]     red,
    output logic [GREEN_W-1:0]   green,
    output logic [BLUE_W-1:0]    blue,
    output logic                 frame_start,
    output logic [15:0]          frame_count,
    output logic                 heartbeat
);

    localparam logic HS_IDLE = (HSYNC_ACTIVE_LOW != 0);
    localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);
    localparam logic VS_ACT  = ~VS_IDLE;

    logic [RGB3_W-1:0] src_rgb;
    logic [RGB3_W-1:0] pix;
    logic [4:0]        pipe_in;
    logic [4:0]        pipe_out;
    logic              frame_edge;
    logic              vs_prev_q, vs_prev_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [15:0]       div_cnt_q, div_cnt_d;
    logic              heartbeat_q, heartbeat_d;
    logic              unused_inputs;

    // Position inputs only feed the optional test-bar source.
    assign unused_inputs = ^{hpos, vpos, pattern_sel};

    always_comb begin
`ifdef VGA_TESTBAR_EN
        if (pattern_sel) begin
            src_rgb = (vpos[8:3] == 6'd0) ? 3'b111 : hpos[8:6];
        end else begin
            src_rgb = rgb_in;
        end
`else
        src_rgb = rgb_in;
`endif
        pix     = display_on ? src_rgb : '0;
        pipe_in = {hsync_in, vsync_in, pix};
    end

    vga_delay_line #(
        .WIDTH     (5),
        .DEPTH     (LATENCY),
        .RESET_VAL ({HS_IDLE, VS_IDLE, 3'b000})
    ) u_video_dly (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    // Edge runs through its own equal-depth line so the pulse lines up with vsync at the pins.
    assign vs_prev_d  = vsync_in;
    assign frame_edge = (vsync_in == VS_ACT) && (vs_prev_q != VS_ACT);

    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (LATENCY),
        .RESET_VAL (1'b0)
    ) u_edge_dly (
        .clk   (clk),
        .reset (reset),
        .din   (frame_edge),
        .dout  (frame_start)
    );

    always_comb begin
        frame_count_d = frame_count_q;
        div_cnt_d     = div_cnt_q;
        heartbeat_d   = heartbeat_q;
        if (frame_start) begin
            frame_count_d = frame_count_q + 16'd1;
            if (div_cnt_q == 16'(FRAME_DIV - 1)) begin
                div_cnt_d   = 16'd0;
                heartbeat_d = ~heartbeat_q;
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev_q     <= VS_IDLE;
            frame_count_q <= 16'd0;
            div_cnt_q     <= 16'd0;
            heartbeat_q   <= 1'b0;
        end else begin
            vs_prev_q     <= vs_prev_d;
            frame_count_q <= frame_count_d;
            div_cnt_q     <= div_cnt_d;
            heartbeat_q   <= heartbeat_d;
        end
    end

    assign hsync       = pipe_out[4];
    assign vsync       = pipe_out[3];
    assign red         = RED_W'(expand_bits(pipe_out[0], RED_W));
    assign green       = GREEN_W'(expand_bits(pipe_out[1], GREEN_W));
    assign blue        = BLUE_W'(expand_bits(pipe_out[2], BLUE_W));
    assign frame_count = frame_count_q;
    assign heartbeat   = heartbeat_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench for vga_out_stage: randomized stimulus against a
// history-based reference model of the output stage.
module tb_vga_out_stage;

    localparam int LAT = 2;
    localparam int FD  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, display_on = 1'b0, pattern_sel = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;
    logic [2:0] rgb_in = '0;
    logic       hsync, vsync, frame_start, heartbeat;
    logic [4:0] red, blue;
    logic [5:0] green;
    logic [15:0] frame_count;

    vga_out_stage #(
        .LATENCY(LAT), .VSYNC_ACTIVE_LOW(1), .HSYNC_ACTIVE_LOW(1), .FRAME_DIV(FD)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .rgb_in(rgb_in),
        .pattern_sel(pattern_sel), .hsync(hsync), .vsync(vsync), .red(red),
        .green(green), .blue(blue), .frame_start(frame_start),
        .frame_count(frame_count), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       hs, vs, don, psel;
        bit [2:0] rgb;
        bit [9:0] hpos, vpos;
    } in_t;

    // Inputs sampled since the last reset release, plus running edge totals.
    in_t hist[$];
    int  edges[$];
    int  offset = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    bit  cur_vs = 1'b1;

    function automatic bit vs_act(in_t v);
        return v.vs == 1'b0;
    endfunction

    function automatic bit [2:0] colour_of(in_t v);
        bit [2:0] c;
        c = v.rgb;
`ifdef VGA_TESTBAR_EN
        if (v.psel) begin
            if ((v.vpos % 512) < 8) c = 3'b111;
            else c = 3'((v.hpos / 64) % 8);
        end
`endif
        return v.don ? c : 3'b000;
    endfunction

    function automatic bit [35:0] exp_vec();
        int p, j, frames;
        bit hs, vs, fs, hb;
        bit [2:0] c;
        bit [15:0] fc;
        p = hist.size() - 1;
        j = p - LAT + 1;
        frames = (p - LAT >= 0) ? edges[p - LAT] : 0;
        if (j < 0) begin
            hs = 1'b1; vs = 1'b1; c = 3'b000; fs = 1'b0;
        end else begin
            hs = hist[j].hs;
            vs = hist[j].vs;
            c  = colour_of(hist[j]);
            fs = (edges[j] - ((j > 0) ? edges[j-1] : 0)) != 0;
        end
        fc = 16'((frames + offset) % 65536);
        hb = ((frames / FD) % 2) != 0;
        return {hs, vs, {5{c[0]}}, {6{c[1]}}, {5{c[2]}}, fs, fc, hb};
    endfunction

    function automatic bit [35:0] obs();
        return {hsync, vsync, red, green, blue, frame_start, frame_count, heartbeat};
    endfunction

    function automatic int frames_now();
        int p;
        p = hist.size() - 1;
        return (p - LAT >= 0) ? edges[p - LAT] : 0;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        if ($urandom_range(7) == 0) cur_vs = ~cur_vs;
        v.hs   = 1'($urandom_range(1));
        v.vs   = cur_vs;
        v.don  = 1'($urandom_range(1));
        v.psel = 1'($urandom_range(1));
        v.rgb  = 3'($urandom_range(7));
        v.hpos = 10'($urandom_range(1023));
        v.vpos = 10'($urandom_range(1023));
        return v;
    endfunction

    task automatic step(input in_t v);
        int n;
        bit e;
        hsync_in = v.hs; vsync_in = v.vs; display_on = v.don; pattern_sel = v.psel;
        rgb_in = v.rgb; hpos = v.hpos; vpos = v.vpos;
        @(posedge clk);
        if (reset) begin
            hist.push_back(v);
            n = hist.size();
            e = vs_act(v) && ((n == 1) || !vs_act(hist[n-2]));
            edges.push_back(((n > 1) ? edges[n-2] : 0) + int'(e));
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        hist.delete();
        edges.delete();
        offset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        in_t v;
        reset = 1'b0;
        hist.delete(); edges.delete(); offset = 0;
        for (int i = 0; i < 6; i++) begin
            step(rand_in());
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL reset_hold: got %h want %h", obs(), exp_vec());
            end
            n_cmp++;
        end
        reset = 1'b1;
        v = rand_in(); v.don = 1'b1; v.rgb = 3'b101; v.psel = 1'b0;
        step(v);
        step(rand_in());
        if ({red, green, blue} !== {5'h1F, 6'h00, 5'h1F}) begin
            n_fail++;
            $display("[TB] FAIL first_pixel: got %h/%h/%h want 1f/00/1f", red, green, blue);
        end
        n_cmp++;
    endtask

    task automatic test_blanking();
        in_t v;
        for (int i = 0; i < 12; i++) begin
            v = rand_in(); v.don = 1'b0; v.rgb = 3'b111; v.hs = i[1];
            step(v);
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL blanking: got %h want %h", obs(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_frames(input int nframes, input string name);
        in_t v;
        int pulses;
        bit prev_vs;
        apply_reset();
        pulses = 0;
        prev_vs = vsync;
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < 12 + LAT; k++) begin
                v = rand_in();
                v.vs = (k >= 8 && k < 11) ? 1'b0 : 1'b1;
                step(v);
                if (obs() !== exp_vec()) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %h want %h", name, obs(), exp_vec());
                end
                n_cmp++;
                if (frame_start) begin
                    pulses++;
                    if (!(prev_vs === 1'b1 && vsync === 1'b0)) begin
                        n_fail++;
                        $display("[TB] FAIL %s_align: vsync %b->%b want 1->0", name, prev_vs, vsync);
                    end
                    n_cmp++;
                end
                prev_vs = vsync;
            end
        end
        if (pulses != nframes || frame_count !== 16'(nframes)) begin
            n_fail++;
            $display("[TB] FAIL %s_count: pulses %0d count %0d want %0d", name, pulses, frame_count, nframes);
        end
        n_cmp++;
        if (heartbeat !== 1'(((nframes / FD) % 2) != 0)) begin
            n_fail++;
            $display("[TB] FAIL %s_heartbeat: got %b want %0d", name, heartbeat, (nframes / FD) % 2);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            step(rand_in());
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %h want %h", i, obs(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 40; i++) step(rand_in());
        reset = 1'b0;
        hist.delete(); edges.delete(); offset = 0;
        #1;
        if (obs() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h want %h", obs(), exp_vec());
        end
        n_cmp++;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_wrap();
        in_t v;
        int pulses;
        apply_reset();
        for (int i = 0; i < 5; i++) step(rand_in());
        force dut.frame_count_q = 16'hFFFF;
        #1 release dut.frame_count_q;
        offset = 16'hFFFF - frames_now();
        pulses = 0;
        for (int k = 0; k < 12 + LAT; k++) begin
            v = rand_in();
            v.vs = (k >= 6 && k < 9) ? 1'b0 : 1'b1;
            if (k < 2) v.vs = 1'b1;
            step(v);
            if (k >= 2 && frame_start) pulses++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL wrap: got %h want %h", obs(), exp_vec());
            end
            n_cmp++;
        end
        if (frame_count !== 16'h0000 || pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL wrap_final: count %h pulses %0d want 0000 and 1", frame_count, pulses);
        end
        n_cmp++;
    endtask

`ifdef VGA_TESTBAR_EN
    task automatic test_testbar();
        in_t v;
        apply_reset();
        v = rand_in(); v.psel = 1'b1; v.don = 1'b1; v.vpos = 10'd100; v.hpos = 10'd130;
        step(v);
        step(rand_in());
        if ({red, green, blue} !== {5'h00, 6'h3F, 5'h00}) begin
            n_fail++;
            $display("[TB] FAIL testbar_bar: got %h/%h/%h want 00/3f/00", red, green, blue);
        end
        n_cmp++;
        v.vpos = 10'd3;
        step(v);
        step(rand_in());
        if ({red, green, blue} !== {5'h1F, 6'h3F, 5'h1F}) begin
            n_fail++;
            $display("[TB] FAIL testbar_white: got %h/%h/%h want 1f/3f/1f", red, green, blue);
        end
        n_cmp++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_blanking();
        test_frames(3, "frames");
        test_frames(5, "heartbeat");
        test_random();
        test_async_reset();
        test_wrap();
`ifdef VGA_TESTBAR_EN
        test_testbar();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
